// File: rtl/egress_pop_counter_pkg.sv
// Shared sink-side definitions: FSM state encodings and counter-read index codes.
// Reused by the destination FIFOs and the other sink-side consumers.
package egress_pop_counter_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [1:0] IDX_D0  = 2'd0;
    localparam logic [1:0] IDX_D1  = 2'd1;
    localparam logic [1:0] IDX_TOT = 2'd2;
    localparam logic [1:0] IDX_RSV = 2'd3;

endpackage

// File: rtl/egress_pop_counter_rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered token.
// The token only moves when both requesters compete and the grant is actually used.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       update,
    output logic [1:0] grant
);

    logic token;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

    // NOTE: grant gets its default before the case so this always_comb never infers a latch.
    always_comb begin
        grant = 2'b00;
        if (update) begin
            case (request)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = token ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            token <= 1'b0;
        end else if (update && (&request)) begin
            token <= ~token;
        end
    end

endmodule

// File: rtl/egress_pop_counter.sv
// Sink-side consumer for the D0/D1 destination FIFOs: round-robin pops, merged tagged output
// stream, and saturating per-destination word counters readable through req/idx.
module egress_pop_counter
    import egress_pop_counter_pkg::*;
#(
    parameter int BITNUMBER = 8,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 enable,
    input  logic                 D0_can_pop,
    input  logic                 D1_can_pop,
    input  logic [BITNUMBER-1:0] D0_data_out,
    input  logic [BITNUMBER-1:0] D1_data_out,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 dest_out,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic [CNT_W-1:0]     cnt_data,
    output logic                 cnt_valid,
    output logic [1:0]           state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic             pop_ok;
    logic [1:0]       grant;
    logic             rd_valid;
    logic             rd_dest;
    logic [CNT_W-1:0] cnt0, cnt1, total, rd_mux;
    logic [CNT_W:0]   sum;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if (enable && (D0_can_pop || D1_can_pop)) state_d = ST_ACTIVE;
                ST_ACTIVE: if (!enable || !(D0_can_pop || D1_can_pop)) state_d = ST_IDLE;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // ---------------- Pop arbitration ----------------
    // reset is folded in so the strobes stay low while reset is held, before the state settles.
    assign pop_ok = reset && !init && enable && (state_q == ST_ACTIVE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .request ({D1_can_pop, D0_can_pop}),
        .update  (pop_ok),
        .grant   (grant)
    );

    assign pop_D0 = grant[0];
    assign pop_D1 = grant[1];

    // ---------------- Read tracking / merged output ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_dest  <= 1'b0;
        end else begin
            rd_valid <= pop_D0 | pop_D1;
            rd_dest  <= pop_D1;
        end
    end

    // FIFO read data is already registered at the pop edge, so the word is steered by the
    // registered tag rather than captured again, keeping one cycle from pop to valid_out.
    assign valid_out = rd_valid;
    assign dest_out  = rd_dest;
    assign data_out  = !rd_valid ? '0 : (rd_dest ? D1_data_out : D0_data_out);

    // ---------------- Counters ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (init) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop_D0 && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + CNT_ONE;
            if (pop_D1 && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + CNT_ONE;
        end
    end

    assign sum   = {1'b0, cnt0} + {1'b0, cnt1};
    assign total = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

    // ---------------- Counter read port ----------------
    always_comb begin
        rd_mux = '0;
        case (idx)
            IDX_D0:  rd_mux = cnt0;
            IDX_D1:  rd_mux = cnt1;
            IDX_TOT: rd_mux = total;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
        end else begin
            cnt_valid <= req;
            if (req) cnt_data <= rd_mux;
        end
    end

endmodule
